// File: rtl/clk_div_sel.sv
// clk_div_sel: glitch-free selectable clock divider.
// Produces a registered 50% duty divided clock whose half-period comes from a
// parameter table. Rate changes and start/stop only happen on a period
// boundary, so every output period is complete.
module clk_div_sel #(
  parameter int                          NUM_SEL    = 4,
  parameter int                          SEL_W      = 2,
  parameter int                          CNT_W      = 8,
  parameter logic [NUM_SEL*CNT_W-1:0]    HALF_TABLE = 32'h08040201
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] sel_active,
  output logic             pending,
  output logic             running
);

  localparam int              NUM_IDX   = 2 ** SEL_W;
  localparam logic [SEL_W:0]  SEL_LIMIT = (SEL_W + 1)'(NUM_SEL);

  // Half-period lookup, padded to every encodable index; zero entries and
  // unused indices read as 1 so the counter compare is always meaningful.
  logic [CNT_W-1:0] half_arr [NUM_IDX];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IDX; gi = gi + 1) begin : g_half
      if (gi < NUM_SEL) begin : g_entry
        localparam logic [CNT_W-1:0] RAW = HALF_TABLE[gi*CNT_W +: CNT_W];
        assign half_arr[gi] = (RAW == '0) ? CNT_W'(1) : RAW;
      end else begin : g_pad
        assign half_arr[gi] = CNT_W'(1);
      end
    end
  endgenerate

  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic             running_reg, running_next;
  logic [SEL_W-1:0] sel_active_reg, sel_active_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [CNT_W-1:0] half_cur;
  logic [CNT_W-1:0] last_cnt;
  logic             sel_valid;
  logic             phase_end;

  assign half_cur  = half_arr[sel_active_reg];
  assign last_cnt  = half_cur - CNT_W'(1);
  assign sel_valid = ({1'b0, sel} < SEL_LIMIT);
  assign phase_end = (cnt_reg == last_cnt);

  // Next-state: count through each phase; decide rate and run at the low-phase boundary.
  always_comb begin
    clk_out_next    = clk_out_reg;
    tick_next       = 1'b0;
    running_next    = running_reg;
    sel_active_next = sel_active_reg;
    cnt_next        = cnt_reg;
    if (clk_out_reg) begin
      // High phase ignores en and sel entirely.
      if (phase_end) begin
        clk_out_next = 1'b0;
        cnt_next     = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (phase_end || !running_reg) begin
      // Boundary: idle counts as a boundary every cycle.
      if (sel_valid) begin
        sel_active_next = sel;
      end
      cnt_next = '0;
      if (en) begin
        clk_out_next = 1'b1;
        tick_next    = 1'b1;
        running_next = 1'b1;
      end else begin
        running_next = 1'b0;
      end
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out_reg    <= 1'b0;
      tick_reg       <= 1'b0;
      running_reg    <= 1'b0;
      sel_active_reg <= '0;
      cnt_reg        <= '0;
    end else begin
      clk_out_reg    <= clk_out_next;
      tick_reg       <= tick_next;
      running_reg    <= running_next;
      sel_active_reg <= sel_active_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign clk_out    = clk_out_reg;
  assign tick       = tick_reg;
  assign running    = running_reg;
  assign sel_active = sel_active_reg;
  assign pending    = sel_valid && (sel != sel_active_reg);

endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: drives two divider instances (default table, and a
// three-entry table with a zero entry) from shared stimulus and compares
// every cycle against a period-level reference model.
module tb_clk_div_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'd0;

  logic       clk_out [2];
  logic       tick    [2];
  logic [1:0] sel_act [2];
  logic       pending [2];
  logic       running [2];

  int checks = 0;
  int errors = 0;

  // Reference model: one period = H high cycles then H low cycles.
  // m_pos is the cycle index inside the current period.
  int tab  [2][4];
  int nsel [2];
  int m_h  [2];
  int m_pos[2];
  int m_sa [2];
  bit m_run[2];

  always #5 clk = ~clk;

  clk_div_sel dut0 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .clk_out(clk_out[0]), .tick(tick[0]), .sel_active(sel_act[0]),
    .pending(pending[0]), .running(running[0])
  );

  clk_div_sel #(
    .NUM_SEL(3), .SEL_W(2), .CNT_W(8), .HALF_TABLE(24'h000305)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .clk_out(clk_out[1]), .tick(tick[1]), .sel_active(sel_act[1]),
    .pending(pending[1]), .running(running[1])
  );

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%0d expected=%0d t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int k);
    if (rst) begin
      m_run[k] = 1'b0;
      m_sa[k]  = 0;
      m_pos[k] = 0;
    end else if (m_run[k] && (m_pos[k] + 1 < 2 * m_h[k])) begin
      m_pos[k]++;
    end else begin
      if (int'(sel) < nsel[k]) m_sa[k] = int'(sel);
      if (en) begin
        m_run[k] = 1'b1;
        m_pos[k] = 0;
        m_h[k]   = tab[k][m_sa[k]];
      end else begin
        m_run[k] = 1'b0;
        m_pos[k] = 0;
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare on the falling edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s);
    rst = r;
    en  = e;
    sel = s;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("clk_out",    k, int'(clk_out[k]), int'(m_run[k] && (m_pos[k] < m_h[k])));
      chk("tick",       k, int'(tick[k]),    int'(m_run[k] && (m_pos[k] == 0)));
      chk("running",    k, int'(running[k]), int'(m_run[k]));
      chk("sel_active", k, int'(sel_act[k]), m_sa[k]);
      chk("pending",    k, int'(pending[k]),
          int'((int'(sel) < nsel[k]) && (int'(sel) != m_sa[k])));
    end
    $display("step rst=%0d en=%0d sel=%0d | out=%0d/%0d tick=%0d/%0d run=%0d/%0d sa=%0d/%0d",
             r, e, s, clk_out[0], clk_out[1], tick[0], tick[1],
             running[0], running[1], sel_act[0], sel_act[1]);
  endtask

  initial begin
    logic       r_en;
    logic       r_rst;
    logic [1:0] r_sel;

    tab[0] = '{1, 2, 4, 8};
    tab[1] = '{5, 3, 1, 1};
    nsel   = '{4, 3};
    for (int k = 0; k < 2; k++) begin
      m_h[k] = 1; m_pos[k] = 0; m_sa[k] = 0; m_run[k] = 1'b0;
    end

    @(negedge clk);
    // 1: reset held with en=1, then clk/2 output.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'd0);

    // 2: steady sel=2.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 2'd2);

    // 3: run at sel=3, switch to sel=0 on the 2nd high cycle of an 8-cycle phase.
    for (int i = 0; i < 60; i++) begin
      if (m_run[0] && m_h[0] == 8 && m_pos[0] == 1) break;
      step(1'b0, 1'b1, 2'd3);
    end
    chk("reach_sel3_phase", 0, int'(m_h[0] == 8 && m_pos[0] == 1), 1);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 2'd0);

    // 4: sel=1, drop en on the 1st high cycle, then re-raise.
    for (int i = 0; i < 20; i++) begin
      if (m_run[0] && m_h[0] == 2 && m_pos[0] == 0) break;
      step(1'b0, 1'b1, 2'd1);
    end
    chk("reach_sel1_phase", 0, int'(m_h[0] == 2 && m_pos[0] == 0), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd1);

    // 5: reset on the 3rd cycle of an 8-cycle high phase, restart at sel=3.
    for (int i = 0; i < 40; i++) begin
      if (m_run[0] && m_h[0] == 8 && m_pos[0] == 2) break;
      step(1'b0, 1'b1, 2'd3);
    end
    chk("reach_sel3_third", 0, int'(m_h[0] == 8 && m_pos[0] == 2), 1);
    step(1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'd3);

    // 6: second instance: rate 5, out-of-range sel ignored, zero entry gives clk/2.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 2'd2);

    // Randomised run.
    r_sel = 2'd0;
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) r_sel = 2'($urandom_range(0, 3));
      step(r_rst, r_en, r_sel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
